// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous RAM between instruction fetch (I) and load/store (D),
// tagging reads so data returns to its owner MEM_LAT cycles later. Optional anti-starvation: MEM_ARB_STARVE_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              stall
);

    logic               force_i;
    logic               push_vld;
    logic               push_own;
    logic [MEM_LAT:1]   vld_pipe;
    logic [MEM_LAT:1]   own_pipe;  // 1 = D owns the read

`ifdef MEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (!i_req || i_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != CNT_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign force_i = (starve_cnt == CNT_W'(STARVE_MAX));
`else
    assign force_i = 1'b0;
`endif

    // Grants are combinational and held off entirely while reset is asserted.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (d_req && !(i_req && force_i))
                d_gnt = 1'b1;
            else if (i_req)
                i_gnt = 1'b1;
        end
    end

    assign mem_en   = i_gnt | d_gnt;
    assign mem_we   = d_gnt ? d_we : 4'b0000;
    assign mem_addr = d_gnt ? d_addr : i_addr;
    assign mem_din  = d_wdata;

    assign push_vld = i_gnt | (d_gnt && (d_we == 4'b0000));
    assign push_own = d_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe[1] <= push_vld;
            own_pipe[1] <= push_own;
            for (int k = MEM_LAT; k > 1; k--) begin
                vld_pipe[k] <= vld_pipe[k-1];
                own_pipe[k] <= own_pipe[k-1];
            end
        end
    end

    assign i_rvalid = vld_pipe[MEM_LAT] & ~own_pipe[MEM_LAT];
    assign d_rvalid = vld_pipe[MEM_LAT] &  own_pipe[MEM_LAT];
    assign i_rdata  = mem_dout;
    assign d_rdata  = mem_dout;

    assign stall = ~rst & ((i_req & ~i_gnt) | (d_req & ~d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: MEM_LAT=1 and MEM_LAT=2 arbiters, each with a behavioural byte-writable RAM.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---- instance 1: MEM_LAT=1
    logic        i_req1, i_gnt1, i_rvalid1, d_req1, d_gnt1, d_rvalid1, mem_en1, stall1;
    logic [13:0] i_addr1, d_addr1, mem_addr1;
    logic [31:0] i_rdata1, d_rdata1, d_wdata1, mem_din1, mem_dout1;
    logic [3:0]  d_we1, mem_we1;
    logic [31:0] mem1 [0:16383];

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1),
        .mem_dout(mem_dout1), .stall(stall1)
    );

    always @(posedge clk) begin
        if (mem_en1) begin
            if (mem_we1 != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we1[b]) mem1[mem_addr1][8*b +: 8] <= mem_din1[8*b +: 8];
            end else begin
                mem_dout1 <= mem1[mem_addr1];
            end
        end
    end

    // ---- instance 2: MEM_LAT=2
    logic        i_req2, i_gnt2, i_rvalid2, d_req2, d_gnt2, d_rvalid2, mem_en2, stall2;
    logic [13:0] i_addr2, d_addr2, mem_addr2;
    logic [31:0] i_rdata2, d_rdata2, d_wdata2, mem_din2, mem_dout2, rd2a;
    logic [3:0]  d_we2, mem_we2;
    logic [31:0] mem2 [0:16383];

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(3)) u_dut2 (
        .clk(clk), .rst(rst),
        .i_req(i_req2), .i_addr(i_addr2), .i_gnt(i_gnt2), .i_rvalid(i_rvalid2), .i_rdata(i_rdata2),
        .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_din(mem_din2),
        .mem_dout(mem_dout2), .stall(stall2)
    );

    always @(posedge clk) begin
        if (mem_en2) begin
            if (mem_we2 != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we2[b]) mem2[mem_addr2][8*b +: 8] <= mem_din2[8*b +: 8];
            end else begin
                rd2a <= mem2[mem_addr2];
            end
        end
        mem_dout2 <= rd2a;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // starvation expectation for I while both requesters hold
`ifdef MEM_ARB_STARVE_EN
    logic [5:0] exp_ig = 6'b001000;  // bit k = cycle k, I wins on the 4th cycle
`else
    logic [5:0] exp_ig = 6'b000000;
`endif

    initial begin
        for (int k = 0; k < 16384; k++) begin
            mem1[k] = 32'hA000_0000 | k;
            mem2[k] = 32'hA000_0000 | k;
        end
        mem1[14'h30] = 32'h0;
        mem_dout1 = '0; mem_dout2 = '0; rd2a = '0;
        i_req1 = 0; i_addr1 = '0; d_req1 = 0; d_we1 = '0; d_addr1 = '0; d_wdata1 = '0;
        i_req2 = 0; i_addr2 = '0; d_req2 = 0; d_we2 = '0; d_addr2 = '0; d_wdata2 = '0;

        // reset state, with a request pending to confirm grants are blocked
        #3;
        i_req1 = 1'b1; d_req1 = 1'b1;
        #1;
        chk("rst_i_gnt",    i_gnt1,    0);
        chk("rst_d_gnt",    d_gnt1,    0);
        chk("rst_mem_en",   mem_en1,   0);
        chk("rst_mem_we",   mem_we1,   0);
        chk("rst_stall",    stall1,    0);
        chk("rst_i_rvalid", i_rvalid1, 0);
        chk("rst_d_rvalid", d_rvalid1, 0);
        i_req1 = 1'b0; d_req1 = 1'b0;
        next_cycle(); next_cycle();
        rst = 1'b0;

        // I-only reads 0x10..0x12
        for (int c = 0; c < 4; c++) begin
            i_req1  = (c < 3);
            i_addr1 = 14'h10 + 14'(c);
            @(negedge clk);
            chk($sformatf("ionly_gnt%0d", c),    i_gnt1,    (c < 3));
            chk($sformatf("ionly_stall%0d", c),  stall1,    0);
            chk($sformatf("ionly_rvalid%0d", c), i_rvalid1, (c > 0));
            if (c > 0) chk($sformatf("ionly_rdata%0d", c), i_rdata1, 32'hA000_000F + c);
            if (c < 3) chk($sformatf("ionly_addr%0d", c), mem_addr1, 32'h10 + c);
            next_cycle();
        end
        i_req1 = 1'b0;

        // simultaneous: D read 0x20 wins, then I read 0x40
        i_req1 = 1'b1; i_addr1 = 14'h40; d_req1 = 1'b1; d_we1 = 4'b0; d_addr1 = 14'h20;
        @(negedge clk);
        chk("both_d_gnt", d_gnt1, 1);
        chk("both_i_gnt", i_gnt1, 0);
        chk("both_stall", stall1, 1);
        chk("both_addr",  mem_addr1, 32'h20);
        next_cycle();
        d_req1 = 1'b0;
        @(negedge clk);
        chk("both_i_gnt1",    i_gnt1,    1);
        chk("both_d_rvalid1", d_rvalid1, 1);
        chk("both_i_rvalid1", i_rvalid1, 0);
        chk("both_d_rdata1",  d_rdata1,  32'hA000_0020);
        chk("both_stall1",    stall1,    0);
        next_cycle();
        i_req1 = 1'b0;
        @(negedge clk);
        chk("both_i_rvalid2", i_rvalid1, 1);
        chk("both_d_rvalid2", d_rvalid1, 0);
        chk("both_i_rdata2",  i_rdata1,  32'hA000_0040);
        next_cycle();

        // partial store then read-back of 0x30
        d_req1 = 1'b1; d_we1 = 4'b0011; d_addr1 = 14'h30; d_wdata1 = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("st_gnt",    d_gnt1,  1);
        chk("st_mem_we", mem_we1, 32'h3);
        chk("st_din",    mem_din1, 32'hDEAD_BEEF);
        next_cycle();
        d_we1 = 4'b0000;
        @(negedge clk);
        chk("ld_gnt",        d_gnt1,    1);
        chk("ld_mem_we",     mem_we1,   0);
        chk("st_no_rvalid",  d_rvalid1, 0);
        next_cycle();
        d_req1 = 1'b0;
        @(negedge clk);
        chk("ld_rvalid", d_rvalid1, 1);
        chk("ld_rdata",  d_rdata1,  32'h0000_BEEF);
        next_cycle();

        // starvation: both requesters hold for 6 cycles
        i_req1 = 1'b1; i_addr1 = 14'h50; d_req1 = 1'b1; d_addr1 = 14'h60;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("starve_i_gnt%0d", c), i_gnt1, exp_ig[c]);
            chk($sformatf("starve_d_gnt%0d", c), d_gnt1, !exp_ig[c]);
            chk($sformatf("starve_stall%0d", c), stall1, 1);
            next_cycle();
        end
        i_req1 = 1'b0; d_req1 = 1'b0;
        next_cycle(); next_cycle();

        // MEM_LAT=2: reads I(0x11), D(0x22), I(0x13)
        for (int c = 0; c < 5; c++) begin
            i_req2  = (c == 0) || (c == 2);
            i_addr2 = (c == 0) ? 14'h11 : 14'h13;
            d_req2  = (c == 1);
            d_addr2 = 14'h22;
            @(negedge clk);
            chk($sformatf("lat2_i_rvalid%0d", c), i_rvalid2, (c == 2) || (c == 4));
            chk($sformatf("lat2_d_rvalid%0d", c), d_rvalid2, (c == 3));
            if (c == 2) chk("lat2_rdata2", i_rdata2, 32'hA000_0011);
            if (c == 3) chk("lat2_rdata3", d_rdata2, 32'hA000_0022);
            if (c == 4) chk("lat2_rdata4", i_rdata2, 32'hA000_0013);
            next_cycle();
        end
        i_req2 = 1'b0; d_req2 = 1'b0;
        next_cycle();

        // async reset with reads in flight
        i_req2 = 1'b1; i_addr2 = 14'h14;
        next_cycle();
        i_req2 = 1'b0; d_req2 = 1'b1; d_addr2 = 14'h15;
        next_cycle();
        d_req2 = 1'b0; i_req2 = 1'b1; i_addr2 = 14'h16;
        @(negedge clk);
        chk("ar_pre_rvalid", i_rvalid2, 1);
        chk("ar_pre_gnt",    i_gnt2,    1);
        #1 rst = 1'b1;
        #1;
        chk("ar_i_gnt",    i_gnt2,    0);
        chk("ar_mem_en",   mem_en2,   0);
        chk("ar_stall",    stall2,    0);
        chk("ar_i_rvalid", i_rvalid2, 0);
        chk("ar_d_rvalid", d_rvalid2, 0);
        i_req2 = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("ar_post_i%0d", c), i_rvalid2, 0);
            chk($sformatf("ar_post_d%0d", c), d_rvalid2, 0);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported synchronous memory (BIOS/DMEM block RAM) between the instruction-fetch requester (port I) and the load/store requester in X (port D). Grants at most one access per cycle and tags each read so its data returns to the right requester after a fixed memory latency. Raises `stall` to the pipeline control while a request waits. By default D has priority, and optional anti-starvation logic guarantees fetch progress.

## Interface
- `ADDR_W`, 14, word-address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles (legal 1..4)
- `STARVE_MAX`, 3, consecutive denied fetch cycles before I is forced ahead of D
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `i_req` in 1: fetch read request
- `i_addr` in ADDR_W: fetch address
- `i_gnt` out 1: fetch accepted this cycle
- `i_rvalid` out 1: `i_rdata` valid
- `i_rdata` out DATA_W: fetch data
- `d_req` in 1: data request
- `d_we` in 4: byte write mask; 0 means read
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: store data
- `d_gnt` out 1: data request accepted this cycle
- `d_rvalid` out 1: `d_rdata` valid (reads only)
- `d_rdata` out DATA_W: load data
- `mem_en` out 1: memory enable
- `mem_we` out 4: memory byte write enables
- `mem_addr` out ADDR_W: memory address
- `mem_din` out DATA_W: memory write data
- `mem_dout` in DATA_W: memory read data, valid MEM_LAT cycles after `mem_en`
- `stall` out 1: some request is pending and not granted

## Operation
- Requesters hold `*_req` and their address/data stable until they see `*_gnt`. Grants are combinational in the same cycle as the request.
- Grant rule: if only one request is active, grant it. If both are active, grant D unless `force_i` is set (see Configuration), in which case grant I.
- On a grant, drive `mem_en=1`, route the winner's address onto `mem_addr`, and set `mem_we = d_we` for D and 0 for I. `mem_din = d_wdata` whenever D is granted. With no grant, `mem_en=0` and `mem_we=0`.
- Tag pipeline: a MEM_LAT-deep shift register of {valid, owner}. A read grant pushes {1, owner}; a write grant or idle cycle pushes {0, x}.
- Response: at the tail of the tag pipeline, raise `i_rvalid` or `d_rvalid` for that owner. Both `i_rdata` and `d_rdata` are wired directly to `mem_dout`.
- `stall = (i_req & ~i_gnt) | (d_req & ~d_gnt)`.
- `rst` high: all grants are forced to 0, `mem_en=0`, the tag pipeline clears, and the starvation counter clears. Reads in flight at reset never produce `rvalid`.

## Timing
- Read latency: grant in cycle N produces `rvalid` in cycle N+MEM_LAT.
- Throughput: one access per cycle. Back-to-back grants return back-to-back `rvalid` pulses in the same order they were granted.
- Stores complete in the grant cycle and produce no response.
- Reset values: `i_gnt=d_gnt=i_rvalid=d_rvalid=mem_en=stall=0`, `mem_we=0`, starvation counter 0.
- Simultaneous requests: exactly one grant. The loser stays pending and `stall=1`.
- Grant and response in the same cycle are independent: a new grant can issue while an older read's `rvalid` is asserted.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - `starve_cnt` is $clog2(STARVE_MAX+1) bits wide and saturates at STARVE_MAX.
  - It increments each cycle `i_req & ~i_gnt`.
  - It clears on `i_gnt` or when `i_req=0`.
  - `force_i = (starve_cnt == STARVE_MAX)`.
- `MEM_ARB_STARVE_EN` undefined: no counter, `force_i=0`, and D has strict priority.

## Test plan
- I-only reads at addresses 0x10, 0x11, 0x12 in consecutive cycles (MEM_LAT=1) -> `i_gnt` in cycles 0–2; `i_rvalid` in cycles 1–3 carrying the contents of 0x10, 0x11, 0x12; `stall=0` throughout.
- `i_req` and `d_req` (read 0x20) both asserted in cycle 0 -> `d_gnt=1`, `i_gnt=0`, `stall=1`. I is granted in cycle 1, `d_rvalid` in cycle 1, `i_rvalid` in cycle 2.
- D store `d_we=4'b0011`, `d_wdata=0xDEADBEEF` to 0x30, then D read of 0x30 -> `mem_we=0011` in the grant cycle, no `d_rvalid` for the store, read returns 0x0000BEEF when 0x30 was previously 0.
- Starvation with `MEM_ARB_STARVE_EN` defined and STARVE_MAX=3: `i_req` held while `d_req` is held continuously -> I is denied for 3 cycles and granted in the 4th, then D resumes. Without the macro, I is never granted while `d_req` stays high.
- MEM_LAT=2 with mixed reads I, D, I in cycles 0–2 -> `rvalid` on I, D, I in cycles 2–4, each carrying its matching data.
- Assert `rst` asynchronously mid-cycle with 2 reads in flight -> all outputs drop to 0 immediately, and no `rvalid` appears after `rst` deasserts.
